// File: rtl/uart_pkg.sv
// Shared constants and types for the UART receive path.
package uart_pkg;

    localparam int B115200 = 434;   // 50 MHz / 115200
    localparam int B9600   = 5208;  // 50 MHz / 9600

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

endpackage

// File: rtl/baudtick_rx.sv
// Bit-period timer for the UART receiver: restarts on clr and marks
// the half-bit point and each full bit period measured from that restart.
module baudtick_rx #(
    parameter int DIVISOR = 434
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    output logic tick_half,
    output logic tick
);

    localparam int CW = $clog2(DIVISOR);
    localparam logic [CW-1:0] HALF_LAST = CW'(DIVISOR / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(DIVISOR - 1);

    logic [CW-1:0] cnt;

    // cnt holds k-1 in the k-th cycle after clr, so the strobes land on
    // the cycle that is DIVISOR/2 (resp. DIVISOR) cycles after the clear.
    always_ff @(posedge clk) begin
        if (!rstn || clr) begin
            cnt <= '0;
        end else if (cnt == FULL_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick_half = (cnt == HALF_LAST);
    assign tick      = (cnt == FULL_LAST);

endmodule

// File: rtl/async_rx.sv
// 8N1 UART receiver: synchronizes rx, frames start/data/stop at a fixed
// divisor and strobes each good byte out on rcv for one cycle.
module async_rx
    import uart_pkg::*;
#(
    parameter int DIVISOR = B115200
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rx,
    output logic [7:0] data,
    output logic       rcv,
    output logic       frame_err,
    output logic       busy
);

    rx_state_t  state, state_nxt;
    logic       rx_meta, rx_s;
    logic       baud_clr, tick_half, tick;
    logic [2:0] bitc, bitc_nxt;
    logic [7:0] shreg;
    logic       shift_en, frame_ok, frame_bad;

    // Two-flop synchronizer; resets to the idle line level.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    baudtick_rx #(
        .DIVISOR(DIVISOR)
    ) u_baud (
        .clk      (clk),
        .rstn     (rstn),
        .clr      (baud_clr),
        .tick_half(tick_half),
        .tick     (tick)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
            bitc  <= 3'd0;
        end else begin
            state <= state_nxt;
            bitc  <= bitc_nxt;
        end
    end

    // Every transition restarts the bit timer so each state times from its own entry.
    always_comb begin
        state_nxt = state;
        bitc_nxt  = bitc;
        baud_clr  = 1'b0;
        shift_en  = 1'b0;
        frame_ok  = 1'b0;
        frame_bad = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_nxt = START;
                    baud_clr  = 1'b1;
                end
            end
            START: begin
                if (tick_half) begin
                    baud_clr = 1'b1;
                    if (!rx_s) begin
                        state_nxt = DATA;
                        bitc_nxt  = 3'd0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    shift_en = 1'b1;
                    bitc_nxt = bitc + 3'd1;
                    if (bitc == 3'd7) begin
                        state_nxt = STOP;
                        baud_clr  = 1'b1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    baud_clr = 1'b1;
                    if (rx_s) begin
                        frame_ok  = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        frame_bad = 1'b1;
                        state_nxt = BREAK;
                    end
                end
            end
            BREAK: begin
                // Hold here until the line returns high so a break cannot start a frame.
                if (rx_s) begin
                    state_nxt = IDLE;
                    baud_clr  = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                baud_clr  = 1'b1;
            end
        endcase
    end

    // LSB arrives first, so bits enter at the top and walk down.
    always_ff @(posedge clk) begin
        if (shift_en) begin
            shreg <= {rx_s, shreg[7:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            data      <= 8'h00;
            rcv       <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rcv <= frame_ok;
            if (frame_ok) begin
                data      <= shreg;
                frame_err <= 1'b0;
            end else if (frame_bad) begin
                frame_err <= 1'b1;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_async_rx.sv
// Randomized bench for async_rx: an 8N1 line driver feeds two receivers
// (divisor 8 and 434) and a queue-based frame model predicts every strobe.
module tb_async_rx;

    localparam int D8 = 8;
    localparam int DL = 434;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       rx8 = 1'b1;
    logic       rx4 = 1'b1;
    logic [7:0] data8, data4;
    logic       rcv8, rcv4, fe8, fe4, busy8, busy4;

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    async_rx #(.DIVISOR(D8)) dut8 (
        .clk(clk), .rstn(rstn), .rx(rx8),
        .data(data8), .rcv(rcv8), .frame_err(fe8), .busy(busy8)
    );

    async_rx #(.DIVISOR(DL)) dut434 (
        .clk(clk), .rstn(rstn), .rx(rx4),
        .data(data4), .rcv(rcv4), .frame_err(fe4), .busy(busy4)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Frame model: every well-framed byte sent is owed exactly one strobe,
    // in order, at start + 2 (sync) + D/2 + 9*D + 1.
    logic [7:0]  q8[$], q4[$];
    int unsigned s8[$], s4[$];
    logic [7:0]  last8 = 8'h00, last4 = 8'h00;
    int          exp_n8 = 0, exp_n4 = 0;
    int          rcvn8 = 0, rcvn4 = 0;
    int unsigned rcv_t8 = 0, rcv_tp8 = 0;
    logic        rcv8_d = 1'b0, rcv4_d = 1'b0;

    task automatic on_rcv(input int sel);
        logic [7:0]  b;
        int unsigned s, want;
        if (sel == 0) begin
            if (q8.size() == 0) begin
                chk("rcv8_spurious", 32'(1), 32'(0));
            end else begin
                b = q8.pop_front();
                s = s8.pop_front();
                want = s + 2 + D8 / 2 + 9 * D8 + 1;
                chk("rcv8_data", 32'(data8), 32'(b));
                chk("rcv8_cycle", (cyc + 1 >= want && cyc <= want + 1) ? want : cyc, want);
            end
        end else begin
            if (q4.size() == 0) begin
                chk("rcv434_spurious", 32'(1), 32'(0));
            end else begin
                b = q4.pop_front();
                s = s4.pop_front();
                want = s + 2 + DL / 2 + 9 * DL + 1;
                chk("rcv434_data", 32'(data4), 32'(b));
                chk("rcv434_cycle", (cyc + 1 >= want && cyc <= want + 1) ? want : cyc, want);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rcv8_d) chk("rcv8_one_cycle", 32'(rcv8), 32'(0));
        if (rcv4_d) chk("rcv434_one_cycle", 32'(rcv4), 32'(0));
        if (rcv8) begin
            rcvn8++;
            rcv_tp8 = rcv_t8;
            rcv_t8  = cyc;
            on_rcv(0);
        end
        if (rcv4) begin
            rcvn4++;
            on_rcv(1);
        end
        rcv8_d = rcv8;
        rcv4_d = rcv4;
    end

    task automatic waitc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_rx(input int sel, input logic v);
        if (sel == 0) rx8 = v;
        else          rx4 = v;
    endtask

    // Drives one 8N1 frame and checks the status the model expects once the stop bit ends.
    task automatic send(input int sel, input logic [7:0] b, input logic stop);
        int d;
        d = (sel == 0) ? D8 : DL;
        set_rx(sel, 1'b0);
        if (stop) begin
            if (sel == 0) begin q8.push_back(b); s8.push_back(cyc); exp_n8++; end
            else          begin q4.push_back(b); s4.push_back(cyc); exp_n4++; end
        end
        waitc(d);
        for (int i = 0; i < 8; i++) begin
            set_rx(sel, b[i]);
            waitc(d);
            if (i == 0) chk("busy_in_frame", 32'(sel == 0 ? busy8 : busy4), 32'(1));
        end
        set_rx(sel, stop);
        waitc(d);
        if (stop) begin
            if (sel == 0) last8 = b;
            else          last4 = b;
        end
        chk("frame_err_after", 32'(sel == 0 ? fe8 : fe4), 32'(!stop));
        chk("data_after", 32'(sel == 0 ? data8 : data4), 32'(sel == 0 ? last8 : last4));
        chk("busy_after", 32'(sel == 0 ? busy8 : busy4), 32'(!stop));
    endtask

    initial begin
        logic [7:0] b;
        logic       stop;

        rstn = 1'b0;
        waitc(3);
        chk("rst_data", 32'(data8), 32'(0));
        chk("rst_rcv", 32'(rcv8), 32'(0));
        chk("rst_frame_err", 32'(fe8), 32'(0));
        chk("rst_busy", 32'(busy8), 32'(0));
        chk("rst_busy434", 32'(busy4), 32'(0));
        rstn = 1'b1;
        waitc(20);

        // Short low pulse: rejected at the half-bit check.
        rx8 = 1'b0;
        waitc(2);
        rx8 = 1'b1;
        waitc(2);
        chk("glitch_busy", 32'(busy8), 32'(1));
        waitc(10);
        chk("glitch_idle", 32'(busy8), 32'(0));
        chk("glitch_data", 32'(data8), 32'(0));
        chk("glitch_rcv_count", 32'(rcvn8), 32'(0));

        send(0, 8'h55, 1'b1);
        waitc(5);
        chk("good_rcv_count", 32'(rcvn8), 32'(1));

        // Bad stop bit followed by a held-low break.
        send(0, 8'hA3, 1'b0);
        waitc(30);
        chk("break_busy", 32'(busy8), 32'(1));
        chk("break_frame_err", 32'(fe8), 32'(1));
        chk("break_rcv_count", 32'(rcvn8), 32'(1));
        rx8 = 1'b1;
        waitc(5);
        chk("break_release", 32'(busy8), 32'(0));
        chk("frame_err_sticky", 32'(fe8), 32'(1));
        send(0, 8'h3C, 1'b1);
        waitc(4);

        send(0, 8'h00, 1'b1);
        send(0, 8'hFF, 1'b1);
        waitc(4);
        chk("b2b_spacing", rcv_t8 - rcv_tp8, 32'(80));

        // Reset during data bit 4 of 0x81, with frame_err set beforehand.
        send(0, 8'hA5, 1'b0);
        rx8 = 1'b1;
        waitc(4);
        b = 8'h81;
        rx8 = 1'b0;
        waitc(D8);
        for (int i = 0; i < 4; i++) begin
            rx8 = b[i];
            waitc(D8);
        end
        rx8 = b[4];
        waitc(4);
        rstn = 1'b0;
        waitc(1);
        chk("midrst_data", 32'(data8), 32'(0));
        chk("midrst_rcv", 32'(rcv8), 32'(0));
        chk("midrst_busy", 32'(busy8), 32'(0));
        chk("midrst_frame_err", 32'(fe8), 32'(0));
        rx8 = 1'b1;
        rstn = 1'b1;
        last8 = 8'h00;
        last4 = 8'h00;
        waitc(10);
        send(0, 8'h81, 1'b1);
        waitc(3);

        // Loopback of every byte value with random idle gaps.
        for (int v = 0; v < 256; v++) begin
            send(0, 8'(v), 1'b1);
            waitc($urandom_range(0, 2));
        end

        // Random bytes with occasional framing errors.
        for (int k = 0; k < 24; k++) begin
            b = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            send(0, b, stop);
            if (!stop) begin
                rx8 = 1'b1;
                waitc($urandom_range(3, 6));
            end else begin
                waitc($urandom_range(0, 3));
            end
        end

        // Production divisor.
        send(1, 8'($urandom), 1'b1);
        send(1, 8'($urandom), 1'b0);
        rx4 = 1'b1;
        waitc(5);
        send(1, 8'($urandom), 1'b1);

        waitc(5);
        chk("total_rcv8", 32'(rcvn8), 32'(exp_n8));
        chk("pending_rcv8", 32'(q8.size()), 32'(0));
        chk("total_rcv434", 32'(rcvn4), 32'(exp_n4));
        chk("pending_rcv434", 32'(q4.size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
